// File: rtl/oled_spi_driver.sv
// SSD1306 128x64 driver over 4-wire SPI: hardware reset, fixed init sequence,
// then continuous frame refresh (address preamble + page-ordered frame bytes).
module oled_spi_driver #(
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned RESET_CYCLES = 1000,
   parameter int unsigned FRAME_BYTES  = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   output logic [9:0] byte_counter,
   output logic       frame_start,
   output logic       busy_init,
   output logic       oled_sclk,
   output logic       oled_mosi,
   output logic       oled_dc,
   output logic       oled_cs_n,
   output logic       oled_res_n
);

   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned WAIT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RESET_CYCLES - 1);
   localparam logic [9:0]        LAST_BYTE = 10'(FRAME_BYTES - 1);
   localparam logic [4:0]        INIT_LAST = 5'd24;
   localparam logic [4:0]        ADDR_LAST = 5'd5;

   typedef enum logic [2:0] {RST_HOLD, RST_WAIT, INIT, ADDR, DATA} state_t;
   typedef enum logic [1:0] {LOAD0, LOAD1, SHIFT} phase_t;

   state_t              state, next_state;
   phase_t              phase;
   logic [DIV_W-1:0]    div_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [2:0]          bit_cnt;
   logic [4:0]          cmd_idx;
   logic [7:0]          shreg;
   logic [7:0]          rom_byte;
   logic                byte_done;
   logic                rst_active;

   function automatic logic [7:0] init_rom(input logic [4:0] i);
      case (i)
         5'd0:  init_rom = 8'hAE;
         5'd1:  init_rom = 8'hD5;
         5'd2:  init_rom = 8'h80;
         5'd3:  init_rom = 8'hA8;
         5'd4:  init_rom = 8'h3F;
         5'd5:  init_rom = 8'hD3;
         5'd6:  init_rom = 8'h00;
         5'd7:  init_rom = 8'h40;
         5'd8:  init_rom = 8'h8D;
         5'd9:  init_rom = 8'h14;
         5'd10: init_rom = 8'h20;
         5'd11: init_rom = 8'h00;
         5'd12: init_rom = 8'hA1;
         5'd13: init_rom = 8'hC8;
         5'd14: init_rom = 8'hDA;
         5'd15: init_rom = 8'h12;
         5'd16: init_rom = 8'h81;
         5'd17: init_rom = 8'hCF;
         5'd18: init_rom = 8'hD9;
         5'd19: init_rom = 8'hF1;
         5'd20: init_rom = 8'hDB;
         5'd21: init_rom = 8'h40;
         5'd22: init_rom = 8'hA4;
         5'd23: init_rom = 8'hA6;
         5'd24: init_rom = 8'hAF;
         default: init_rom = 8'h00;
      endcase
   endfunction

   // Column window 0..127, page window 0..7.
   function automatic logic [7:0] addr_rom(input logic [4:0] i);
      case (i)
         5'd0: addr_rom = 8'h21;
         5'd1: addr_rom = 8'h00;
         5'd2: addr_rom = 8'h7F;
         5'd3: addr_rom = 8'h22;
         5'd4: addr_rom = 8'h00;
         5'd5: addr_rom = 8'h07;
         default: addr_rom = 8'h00;
      endcase
   endfunction

   assign rst_active = (state == RST_HOLD) || (state == RST_WAIT);
   assign byte_done  = (phase == SHIFT) && oled_sclk && (div_cnt == DIV_LAST) && (bit_cnt == 3'd7);
   assign rom_byte   = (state == ADDR) ? addr_rom(cmd_idx) : init_rom(cmd_idx);
   assign oled_mosi  = shreg[7];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RST_HOLD;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         RST_HOLD: if (wait_cnt == WAIT_LAST) next_state = RST_WAIT;
         RST_WAIT: if (wait_cnt == WAIT_LAST) next_state = INIT;
         INIT:     if (byte_done && cmd_idx == INIT_LAST) next_state = ADDR;
         ADDR:     if (byte_done && cmd_idx == ADDR_LAST) next_state = DATA;
         DATA:     if (byte_done && byte_counter == LAST_BYTE) next_state = ADDR;
         default:  next_state = RST_HOLD;
      endcase
   end

   always_comb begin
      busy_init  = rst_active || (state == INIT);
      oled_res_n = (state != RST_HOLD);
      oled_cs_n  = rst_active;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_cnt <= '0;
      else if (rst_active && state == next_state) wait_cnt <= wait_cnt + 1'b1;
      else wait_cnt <= '0;
   end

   // byte_counter is updated on the edge entering LOAD0 so the source sees the
   // address during LOAD0 and its registered data_in is ready for LOAD1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase        <= LOAD0;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         cmd_idx      <= '0;
         shreg        <= '0;
         byte_counter <= '0;
         frame_start  <= 1'b0;
         oled_sclk    <= 1'b0;
         oled_dc      <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (rst_active) begin
            phase        <= LOAD0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            cmd_idx      <= '0;
            byte_counter <= '0;
            oled_sclk    <= 1'b0;
         end else begin
            case (phase)
               LOAD0: begin
                  oled_dc     <= (state == DATA);
                  frame_start <= (state == DATA) && (byte_counter == '0);
                  phase       <= LOAD1;
               end
               LOAD1: begin
                  shreg   <= (state == DATA) ? data_in : rom_byte;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  phase   <= SHIFT;
               end
               SHIFT: begin
                  if (div_cnt == DIV_LAST) begin
                     div_cnt   <= '0;
                     oled_sclk <= ~oled_sclk;
                     if (oled_sclk) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                           phase <= LOAD0;
                           if (next_state != state) begin
                              cmd_idx      <= '0;
                              byte_counter <= '0;
                           end else if (state == DATA) begin
                              byte_counter <= byte_counter + 10'd1;
                           end else begin
                              cmd_idx <= cmd_idx + 5'd1;
                           end
                        end
                     end
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               default: phase <= LOAD0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_oled_spi_driver.sv
// Directed bench for oled_spi_driver: SPI capture on sclk rise, frame/data checks,
// timing checks and an asynchronous reset in the middle of a data byte.
module tb_oled_spi_driver;

   localparam int unsigned CLK_DIV = 2;
   localparam int unsigned RST_CYC = 10;
   localparam int unsigned BYTE_T  = 2 + 16 * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data_in = '0;
   logic [9:0] byte_counter;
   logic       frame_start, busy_init, oled_sclk, oled_mosi, oled_dc, oled_cs_n, oled_res_n;

   oled_spi_driver #(.CLK_DIV(CLK_DIV), .RESET_CYCLES(RST_CYC), .FRAME_BYTES(1024)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .byte_counter(byte_counter),
      .frame_start(frame_start), .busy_init(busy_init), .oled_sclk(oled_sclk),
      .oled_mosi(oled_mosi), .oled_dc(oled_dc), .oled_cs_n(oled_cs_n), .oled_res_n(oled_res_n)
   );

   always #5 clk = ~clk;

   // Frame source: registered read, one clk latency.
   always @(posedge clk) data_in <= byte_counter[7:0];

   logic [7:0] init_exp [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                                8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                                8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
   logic [7:0] addr_exp [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [7:0] cap_b [$];
   logic       cap_dc [$];
   logic [9:0] cap_bc [$];
   int         fs_cyc [$];

   int   cyc = 0, bitcnt = 0, falls = 0, hi_w = 0, lo_w = 0;
   int   width_bad = 0, stable_bad = 0;
   logic [7:0] sh = '0;
   logic prev_sclk = 0, prev_mosi = 0, prev_dc = 0, prev_busy = 1;
   logic busy_before_fall = 0, busy_after_fall = 1;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         bitcnt = 0; falls = 0; hi_w = 0; lo_w = 0;
      end else begin
         if (prev_sclk && oled_sclk && (oled_mosi !== prev_mosi || oled_dc !== prev_dc))
            stable_bad++;
         if (oled_sclk && !prev_sclk) begin
            if (falls > 0 && lo_w != CLK_DIV && lo_w != CLK_DIV + 2) width_bad++;
            hi_w = 1;
            sh = {sh[6:0], oled_mosi};
            bitcnt++;
            if (bitcnt == 8) begin
               cap_b.push_back(sh);
               cap_dc.push_back(oled_dc);
               cap_bc.push_back(byte_counter);
               bitcnt = 0;
            end
         end else if (!oled_sclk && prev_sclk) begin
            if (hi_w != CLK_DIV) width_bad++;
            lo_w = 1;
            falls++;
            if (falls == 200) begin
               busy_before_fall = prev_busy;
               busy_after_fall  = busy_init;
            end
         end else if (oled_sclk) hi_w++;
         else lo_w++;
         if (frame_start) fs_cyc.push_back(cyc);
      end
      prev_sclk = oled_sclk; prev_mosi = oled_mosi; prev_dc = oled_dc; prev_busy = busy_init;
   end

   task automatic check_reset_values(input string pfx);
      check({pfx, "_bc"},    32'(byte_counter), 0);
      check({pfx, "_fs"},    32'(frame_start), 0);
      check({pfx, "_busy"},  32'(busy_init), 1);
      check({pfx, "_sclk"},  32'(oled_sclk), 0);
      check({pfx, "_mosi"},  32'(oled_mosi), 0);
      check({pfx, "_dc"},    32'(oled_dc), 0);
      check({pfx, "_cs_n"},  32'(oled_cs_n), 1);
      check({pfx, "_res_n"}, 32'(oled_res_n), 0);
   endtask

   task automatic release_and_time(input string pfx);
      int res_at, rise_at;
      res_at = 0; rise_at = 0;
      @(negedge clk); rst_n = 1'b1;
      for (int n = 1; n <= 200 && rise_at == 0; n++) begin
         @(posedge clk); #1;
         if (oled_res_n && res_at == 0) res_at = n;
         if (oled_sclk) rise_at = n;
      end
      check({pfx, "_res_rise"},  32'(res_at), RST_CYC);
      check({pfx, "_sclk_rise"}, 32'(rise_at), 2 * RST_CYC + 2 + CLK_DIV);
   endtask

   initial begin
      int ncap, nfs, data_bad, cmd_dc_bad, found;
      repeat (3) @(posedge clk);
      #1 check_reset_values("por");
      release_and_time("boot");

      found = 0;
      for (int n = 0; n < 80000 && found == 0; n++) begin
         @(posedge clk); #1;
         if (fs_cyc.size() >= 2 && byte_counter == 10'd500) found = 1;
      end
      check("reach_byte500", 32'(found), 1);

      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_values("async");
      ncap = cap_b.size();
      nfs  = fs_cyc.size();

      check("frame_pulses", 32'(nfs), 2);
      if (nfs >= 2) check("frame_interval", 32'(fs_cyc[1] - fs_cyc[0]), 1030 * BYTE_T);
      check("bytes_before_reset", 32'(ncap), 25 + 6 + 1024 + 6 + 500);
      check("busy_before_fall200", 32'(busy_before_fall), 1);
      check("busy_after_fall200", 32'(busy_after_fall), 0);

      if (ncap >= 1061) begin
         cmd_dc_bad = 0;
         for (int i = 0; i < 25; i++) begin
            check($sformatf("init%0d", i), 32'(cap_b[i]), 32'(init_exp[i]));
            if (cap_dc[i] !== 1'b0) cmd_dc_bad++;
         end
         for (int j = 0; j < 6; j++) begin
            check($sformatf("addr1_%0d", j), 32'(cap_b[25 + j]), 32'(addr_exp[j]));
            check($sformatf("addr2_%0d", j), 32'(cap_b[1055 + j]), 32'(addr_exp[j]));
            if (cap_dc[25 + j] !== 1'b0 || cap_dc[1055 + j] !== 1'b0) cmd_dc_bad++;
            if (cap_bc[1055 + j] !== 10'd0) cmd_dc_bad++;
         end
         check("cmd_dc_and_bc", 32'(cmd_dc_bad), 0);
         data_bad = 0;
         for (int k = 0; k < 1024; k++)
            if (cap_b[31 + k] !== k[7:0] || cap_dc[31 + k] !== 1'b1 || cap_bc[31 + k] !== k[9:0])
               data_bad++;
         for (int i = 1061; i < ncap; i++) begin
            int k;
            k = i - 1061;
            if (cap_b[i] !== k[7:0] || cap_dc[i] !== 1'b1 || cap_bc[i] !== k[9:0]) data_bad++;
         end
         check("data_bytes", 32'(data_bad), 0);
      end

      repeat (2) @(posedge clk);
      release_and_time("restart");
      found = 0;
      for (int n = 0; n < 200 && found == 0; n++) begin
         @(posedge clk); #1;
         if (cap_b.size() > ncap) found = 1;
      end
      check("restart_byte_seen", 32'(found), 1);
      if (found == 1) begin
         check("restart_byte", 32'(cap_b[ncap]), 32'h AE);
         check("restart_dc", 32'(cap_dc[ncap]), 0);
      end

      check("sclk_widths", 32'(width_bad), 0);
      check("stable_while_high", 32'(stable_bad), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
